// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr
//   N-input, W-bit registered multiplexer with valid/ready handshakes on
//   every input channel and on the single output. Selection is either a
//   fixed external index (mode=0) or fair round-robin among valid inputs
//   (mode=1). One output register stage, full throughput when the consumer
//   drains every cycle.
//
//   Optional build macro: MUX_STALL_CNT_EN adds a saturating 16-bit count of
//   cycles the output spent stalled (out_valid && !out_ready).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    N*W  channel i occupies bits [i*W +: W]
//   in_valid   N    per-channel valid
//   in_ready   N    per-channel ready, one-hot or zero (combinational)
//   mode       1    0 = fixed select, 1 = round-robin
//   sel        SW   channel index for fixed mode; values >= N select nothing
//   out_data   W    registered data
//   out_valid  1    registered valid
//   out_ready  1    consumer ready
//   out_sel    SW   channel index that produced out_data
//   stall_cnt  16   stall cycle counter (only with MUX_STALL_CNT_EN)

module mux_nto1_rr #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
`ifdef MUX_STALL_CNT_EN
    output logic [15:0]    stall_cnt,
`endif
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
);

    logic [W-1:0]  out_data_q;
    logic          out_valid_q;
    logic [SW-1:0] out_sel_q;
    logic [SW-1:0] last_grant_q;

    logic          load;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    int unsigned   rr_idx;

    assign load = !out_valid_q || out_ready;

    // Grant selection. Round-robin scans last_grant+1 .. last_grant+N
    // (mod N) and keeps the first valid channel found.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SW'(i) && |(in_valid & (N'(1) << i))) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                rr_idx = (32'(last_grant_q) + k) % N;
                if (!grant_vld && |(in_valid & (N'(1) << rr_idx))) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(rr_idx);
                end
            end
        end
    end

    assign grant_data = W'(in_data >> (32'(grant_idx) * W));

    // Ready is gated by rst so no producer sees a handshake during reset,
    // even before the output register has been cleared.
    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_vld) begin
            in_ready = N'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sel_q    <= '0;
            last_grant_q <= SW'(N - 1);
        end else if (load) begin
            if (grant_vld) begin
                out_data_q  <= grant_data;
                out_sel_q   <= grant_idx;
                out_valid_q <= 1'b1;
                // Fixed mode leaves the pointer alone so round-robin resumes
                // where it left off.
                if (mode) begin
                    last_grant_q <= grant_idx;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes:
  - fixed: an external select picks the input.
  - round-robin: the block arbitrates fairly among valid inputs.
- Single output register stage. Sits between several producer channels and one shared consumer.
- Direct successor to the combinational 4-to-1 mux.

Parameters:
- N, 4, number of input channels; N >= 2.
- W, 8, data width per channel.
- SW, $clog2(N), select/grant width (localparam, derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit high per cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SW  channel index used in fixed mode; values >= N select nothing
- out_data  output  W  registered data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready
- out_sel  output  SW  index of the channel that produced the current out_data

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer last_grant = N-1, so channel 0 has top priority first.
  - in_ready is combinational, so it is 0 for all channels while rst is high.
- load = !out_valid || out_ready. The output register may accept new data this cycle.
- Grant computation (combinational, from current inputs and state):
  - mode=0: grant g = sel if sel < N and in_valid[sel]; otherwise no grant.
  - mode=1: g = first i with in_valid[i] set, scanning last_grant+1, last_grant+2, … modulo N (wrap-around). No grant if in_valid is all-zero.
- in_ready[g] = load && grant exists. All other in_ready bits are 0. in_ready never depends on in_valid of other channels, except through arbitration.
- Transfer on edge when a grant exists and load=1:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - If mode=1, last_grant <= g.
- Edge with load=1 and no grant: out_valid <= 0. out_data and out_sel hold their last values.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and out_sel are held stable and all in_ready are 0.
- Simultaneous drain and fill: out_ready=1 with a valid grant gives full throughput, one transfer per cycle.
- Latency: an input accepted on edge k appears on out_data/out_valid after edge k (1 cycle).
- Mode switch takes effect in the same cycle (combinational). last_grant is not modified in fixed mode, so round-robin resumes from where it left off.
- Reset mid-transfer: a held output word is discarded (out_valid -> 0) and the pointer returns to N-1.
- in_data of non-granted channels is ignored; producers must hold data while valid and not ready.

Optional Feature:
- Macro MUX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Increments on every edge where out_valid && !out_ready, saturating at 16'hFFFF.
  - Cleared by rst only.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. After release with mode=1, first grant goes to channel 0.
- Fixed mode: N=4, W=8, mode=0, sel=2, in_data={8'hD3,8'hC2,8'hB1,8'hA0}, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=8'hC2, out_sel=2, out_valid=1.
  - sel=1 with in_valid[1]=0 -> no grant, out_valid drops to 0 next cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
  - With in_valid=4'b1010 -> sequence 1,3,1,3 (wrap-around).
- Backpressure: out_ready=0 for 5 cycles after a transfer of 8'h5A -> out_data=8'h5A, out_valid=1 held, in_ready=0 throughout.
  - out_ready=1 -> next channel granted in the same cycle, new data one cycle later.
  - With MUX_STALL_CNT_EN, stall_cnt=5.
- Mode switch: mode=1 until last_grant=1, then mode=0 with sel=3 for 3 transfers, then mode=1 with all valid -> out_sel=3,3,3 then 2.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst for 1 cycle -> out_valid=0 next cycle. Round-robin then restarts at channel 0.
